// File: rtl/tribus_pkg.sv
// Shared types and width helpers for the tri-state bus enable scheduler.
package tribus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StTurn
  } state_e;

  // Width of a field holding 0..n-1; never narrower than one bit.
  function automatic int unsigned idw(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set req bit scanning ptr, ptr+1, ... modulo N_SRC.
module rr_pick
  import tribus_pkg::*;
#(
  parameter int unsigned N_SRC = 4,
  localparam int unsigned IDW = idw(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic             found,
  output logic [IDW-1:0]   idx
);

  int j;

  // Scan from the farthest offset down so the nearest hit to ptr is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % int'(N_SRC);
      if (req[j]) begin
        found = 1'b1;
        idx   = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/tribus_enable_sched.sv
// Break-before-make enable scheduler for transmission-gate switches sharing one tri-state bus.
module tribus_enable_sched
  import tribus_pkg::*;
#(
  parameter int unsigned N_SRC    = 4,
  parameter int unsigned TURN_CYC = 2,
  parameter int unsigned MAX_HOLD = 8,
  localparam int unsigned IDW = idw(N_SRC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] req,
  output logic [N_SRC-1:0] con,
  output logic [IDW-1:0]   grant_id,
  output logic             bus_busy,
  output logic             bus_float,
  output logic             release_p
);

  localparam int unsigned HoldW = idw(MAX_HOLD);
  localparam int unsigned TurnW = idw(TURN_CYC);
  localparam logic [HoldW-1:0] HoldMax  = HoldW'(MAX_HOLD - 1);
  localparam logic [TurnW-1:0] TurnInit = TurnW'(TURN_CYC - 1);

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [TurnW-1:0] turn_q, turn_d;
  logic [N_SRC-1:0] con_q, con_d;
  logic [IDW-1:0]   gid_q, gid_d;
  logic             rel_q, rel_d;

  logic             pick_found;
  logic [IDW-1:0]   pick_idx;
  logic [N_SRC-1:0] pick_oh;
  logic             owner_req, other_req, leave;

  rr_pick #(
    .N_SRC (N_SRC)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign pick_oh = {{(N_SRC - 1){1'b0}}, 1'b1} << pick_idx;

  // con_q is the owner's one-hot mask while driving.
  assign owner_req = |(req & con_q);
  assign other_req = |(req & ~con_q);
  assign leave     = !owner_req || ((hold_q == HoldMax) && other_req);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    con_d   = con_q;
    gid_d   = gid_q;
    rel_d   = 1'b0;
    case (state_q)
      StIdle, StTurn: begin
        if ((state_q == StTurn) && (turn_q != '0)) begin
          turn_d = turn_q - TurnW'(1);
        end else if (pick_found) begin
          state_d = StDrive;
          con_d   = pick_oh;
          gid_d   = pick_idx;
          hold_d  = '0;
        end else begin
          state_d = StIdle;
          con_d   = '0;
        end
      end
      StDrive: begin
        if (leave) begin
          state_d = StTurn;
          con_d   = '0;
          rel_d   = 1'b1;
          turn_d  = TurnInit;
          ptr_d   = (gid_q == IDW'(N_SRC - 1)) ? '0 : gid_q + IDW'(1);
        end else if (hold_q != HoldMax) begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        con_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      hold_q  <= '0;
      turn_q  <= '0;
      con_q   <= '0;
      gid_q   <= '0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
      con_q   <= con_d;
      gid_q   <= gid_d;
      rel_q   <= rel_d;
    end
  end

  assign con       = con_q;
  assign grant_id  = gid_q;
  assign bus_busy  = (state_q == StDrive);
  assign bus_float = (con_q == '0);
  assign release_p = rel_q;

endmodule

// File: tb/tb_tribus_enable_sched.sv
// Directed and randomized checks of the bus enable scheduler (N_SRC=4, TURN_CYC=2, MAX_HOLD=8).
module tb_tribus_enable_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] con;
  logic [1:0] grant_id;
  logic       bus_busy, bus_float, release_p;

  int nvec = 0;
  int nerr = 0;

  tribus_enable_sched #(
    .N_SRC    (4),
    .TURN_CYC (2),
    .MAX_HOLD (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .con       (con),
    .grant_id  (grant_id),
    .bus_busy  (bus_busy),
    .bus_float (bus_float),
    .release_p (release_p)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_con, input logic [1:0] e_gid,
                         input logic e_busy, input logic e_rel);
    chk({tag, ".con"}, 32'(con), 32'(e_con));
    chk({tag, ".gid"}, 32'(grant_id), 32'(e_gid));
    chk({tag, ".busy"}, 32'(bus_busy), 32'(e_busy));
    chk({tag, ".float"}, 32'(bus_float), 32'(e_con == 4'b0000));
    chk({tag, ".rel"}, 32'(release_p), 32'(e_rel));
  endtask

  logic [3:0] exp_con, prev_con;
  logic [3:0] last_owner;
  int         gap;

  initial begin
    rst = 1'b1;
    req = 4'b1111;

    // 1: reset holds everything off even with all requests up.
    tick(); chk_all("rst_c0", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick(); chk_all("rst_c1", 4'b0000, 2'd0, 1'b0, 1'b0);

    // 2: single requester, drop at cycle 5.
    rst = 1'b0;
    req = 4'b0100;
    for (int c = 1; c <= 5; c++) begin
      tick(); chk_all("single_drive", 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    req = 4'b0000;
    tick(); chk_all("single_turn0", 4'b0000, 2'd2, 1'b0, 1'b1);
    tick(); chk_all("single_turn1", 4'b0000, 2'd2, 1'b0, 1'b0);
    tick(); chk_all("single_idle", 4'b0000, 2'd2, 1'b0, 1'b0);

    // 3: two competitors, round-robin with hold limit and 2-cycle gaps.
    rst = 1'b1;
    tick(); chk_all("rst3", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    req = 4'b0011;
    for (int c = 1; c <= 21; c++) begin
      tick();
      exp_con = (c <= 8) ? 4'b0001 : (c <= 10) ? 4'b0000 : (c <= 18) ? 4'b0010 :
                (c <= 20) ? 4'b0000 : 4'b0001;
      chk("rr.con", 32'(con), 32'(exp_con));
      chk("rr.rel", 32'(release_p), 32'((c == 9) || (c == 19)));
    end

    // 4: hold limit against a late competitor, then pointer wrap 3 -> 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b0001;
    for (int c = 1; c <= 21; c++) begin
      tick();
      if (c == 3) req = 4'b1001;
      exp_con = (c <= 8) ? 4'b0001 : (c <= 10) ? 4'b0000 : (c <= 18) ? 4'b1000 :
                (c <= 20) ? 4'b0000 : 4'b0001;
      chk("hold.con", 32'(con), 32'(exp_con));
    end
    chk_all("wrap", 4'b0001, 2'd0, 1'b1, 1'b0);

    // 5: reset mid-drive forces con off and restores ptr to 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b0100;
    for (int c = 1; c <= 4; c++) tick();
    chk_all("pre_rst", 4'b0100, 2'd2, 1'b1, 1'b0);
    rst = 1'b1;
    req = 4'b1111;
    tick(); chk_all("mid_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick(); chk_all("post_rst", 4'b0001, 2'd0, 1'b1, 1'b0);

    // 6: random requests with invariant checks.
    prev_con   = con;
    last_owner = con;
    gap        = 0;
    for (int c = 0; c < 3000; c++) begin
      if ((c % 7) == 0) req = 4'($urandom_range(0, 15));
      tick();
      chk("rnd.onehot0", 32'($onehot0(con)), 32'(1));
      chk("rnd.float", 32'(bus_float), 32'(con == 4'b0000));
      chk("rnd.busy", 32'(bus_busy), 32'(con != 4'b0000));
      chk("rnd.rel", 32'(release_p), 32'((prev_con != 4'b0000) && (con == 4'b0000)));
      if ((prev_con != 4'b0000) && (con != 4'b0000)) begin
        chk("rnd.nodirect", 32'(con), 32'(prev_con));
      end
      if (con == 4'b0000) begin
        gap++;
      end else begin
        if ((gap > 0) && (last_owner != 4'b0000)) begin
          chk("rnd.gap_min", 32'(gap >= 2), 32'(1));
        end
        gap        = 0;
        last_owner = con;
      end
      prev_con = con;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
